// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared FSM state type and default geometry for the RAM BIST controller
package ram_bist_pkg;
   typedef enum logic [2:0] {IDLE, WR, RD, DRAIN, DONE} state_t;
   localparam int DEF_ADDR_W = 14;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_START_ADDR = 2;
   localparam int DEF_STRIDE = 2048;
endpackage

// File: rtl/ram_bist_addr_gen.sv
// ram_bist_addr_gen: strided address sequencer
// Ports: clk, rst; load (restart at START_ADDR), adv (step by STRIDE);
//        addr (address currently presented), nxt (address for next cycle), last (addr is final in range)
module ram_bist_addr_gen
   import ram_bist_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int START_ADDR = DEF_START_ADDR,
   parameter int STRIDE = DEF_STRIDE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              adv,
   output logic [ADDR_W-1:0] addr,
   output logic [ADDR_W-1:0] nxt,
   output logic              last
);
   logic [ADDR_W:0] sum;
   // one extra bit catches the step that would leave the address space
   assign sum = {1'b0, addr} + (ADDR_W+1)'(STRIDE);
   assign last = sum[ADDR_W];
   always_comb nxt = load ? ADDR_W'(START_ADDR) : adv ? sum[ADDR_W-1:0] : addr;
   always_ff @(posedge clk)
      if (rst) addr <= '0;
      else addr <= nxt;
endmodule

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: write/read-back RAM self test with mismatch counting
// Ports: clk, rst (sync, active high), start; RAM side mem_add/mem_in/mem_read/mem_write/mem_en
//        out, mem_out in; status busy, done, pass, err_count, fail_addr. All outputs registered.
// Optional: RAM_BIST_INV_PASS_EN adds a second pass writing the inverted address pattern.
module ram_bist_ctrl
   import ram_bist_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int START_ADDR = DEF_START_ADDR,
   parameter int STRIDE = DEF_STRIDE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] mem_add,
   output logic [DATA_W-1:0] mem_in,
   output logic              mem_read,
   output logic              mem_write,
   output logic              mem_en,
   input  logic [DATA_W-1:0] mem_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [7:0]        err_count,
   output logic [ADDR_W-1:0] fail_addr
);
`ifdef RAM_BIST_INV_PASS_EN
   localparam logic INV_EN = 1'b1;
`else
   localparam logic INV_EN = 1'b0;
`endif
   state_t state, nstate;
   logic load, adv, last, inv, inv_nxt, go, chk_v;
   logic [ADDR_W-1:0] addr, nxt, chk_addr;
   logic [DATA_W-1:0] chk_exp;

   function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic i);
      logic [DATA_W-1:0] d;
      d = DATA_W'(a);
      return i ? ~d : d;
   endfunction

   ram_bist_addr_gen #(.ADDR_W(ADDR_W), .START_ADDR(START_ADDR), .STRIDE(STRIDE)) u_addr (
      .clk(clk), .rst(rst), .load(load), .adv(adv), .addr(addr), .nxt(nxt), .last(last)
   );

   assign go = start && (state == IDLE || state == DONE);

   always_comb begin
      nstate = state;
      load = 1'b0;
      adv = 1'b0;
      inv_nxt = inv;
      case (state)
         IDLE, DONE: if (go) begin nstate = WR; load = 1'b1; inv_nxt = 1'b0; end
         WR: if (last) begin nstate = RD; load = 1'b1; end else adv = 1'b1;
         RD: if (last) nstate = DRAIN; else adv = 1'b1;
         DRAIN: if (INV_EN && !inv) begin nstate = WR; load = 1'b1; inv_nxt = 1'b1; end else nstate = DONE;
         default: nstate = IDLE;
      endcase
   end

   // RAM strobes are registered from the next state so the first write appears right after start is taken
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         inv <= 1'b0;
         mem_add <= '0;
         mem_in <= '0;
         mem_read <= 1'b0;
         mem_write <= 1'b0;
         mem_en <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         pass <= 1'b0;
         err_count <= '0;
         fail_addr <= '0;
         chk_v <= 1'b0;
         chk_addr <= '0;
         chk_exp <= '0;
      end else begin
         state <= nstate;
         inv <= inv_nxt;
         mem_en <= nstate == WR || nstate == RD;
         mem_read <= nstate == WR || nstate == RD;
         mem_write <= nstate == WR;
         mem_add <= (nstate == WR || nstate == RD) ? nxt : '0;
         mem_in <= nstate == WR ? pat(nxt, inv_nxt) : '0;
         busy <= nstate == WR || nstate == RD || nstate == DRAIN;
         done <= state == DONE && !go;
         pass <= state == DONE && !go && err_count == 8'd0;
         // read data returns one cycle after the access, so the expectation travels one stage behind it
         chk_v <= mem_read && !mem_write;
         chk_addr <= mem_add;
         chk_exp <= pat(mem_add, inv);
         if (go) begin
            err_count <= '0;
            fail_addr <= '0;
         end else if (chk_v && mem_out != chk_exp) begin
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (err_count == 8'd0) fail_addr <= chk_addr;
         end
      end
   end
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: self-checking bench for ram_bist_ctrl with a faulty-RAM model
module tb_ram_bist_ctrl;
   localparam int AW = 14;
   localparam int DW = 16;
   localparam int SA = 2;
   localparam int ST = 2048;
`ifdef RAM_BIST_INV_PASS_EN
   localparam int P = 2;
`else
   localparam int P = 1;
`endif

   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [AW-1:0] mem_add, fail_addr;
   logic [DW-1:0] mem_in, mem_out = '0;
   logic mem_read, mem_write, mem_en, busy, done, pass;
   logic [7:0] err_count;
   logic [DW-1:0] ram [0:(1<<AW)-1];

   int n_chk = 0, n_fail = 0;
   int mode = 0, fa = 0, mask = 0;
   int addrs[$];

   typedef struct {int mode; int fa; int mask; int err; int fail; bit pass;} vec_t;
   vec_t tbl[5];

   ram_bist_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .mem_add(mem_add), .mem_in(mem_in),
      .mem_read(mem_read), .mem_write(mem_write), .mem_en(mem_en), .mem_out(mem_out),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_addr(fail_addr)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] fault(input int a, input logic [DW-1:0] d);
      int idx;
      idx = (a - SA) / ST;
      case (mode)
         1: return a == fa ? d ^ 16'h0010 : d;
         2: return '0;
         3: return ((mask >> idx) & 1) != 0 ? d ^ 16'h0001 : d;
         default: return d;
      endcase
   endfunction

   always @(posedge clk)
      if (mem_en && mem_write) ram[mem_add] <= mem_in;
      else if (mem_en && mem_read) mem_out <= fault(int'(mem_add), ram[mem_add]);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // expected RAM activity k cycles after the start-sampling edge
   task automatic check_cycle(input int k);
      int j, q;
      logic w, r;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      j = k % 17;
      q = k / 17;
      w = 1'b0;
      r = 1'b0;
      a = '0;
      d = '0;
      if (k < 17 * P && j < 16) begin
         a = AW'(addrs[j % 8]);
         w = j < 8;
         r = 1'b1;
         d = w ? (q == 1 ? ~DW'(a) : DW'(a)) : '0;
      end
      chk($sformatf("en k=%0d", k), 32'(mem_en), 32'(r));
      chk($sformatf("rd k=%0d", k), 32'(mem_read), 32'(r));
      chk($sformatf("wr k=%0d", k), 32'(mem_write), 32'(w));
      chk($sformatf("add k=%0d", k), 32'(mem_add), 32'(a));
      if (!r || w) chk($sformatf("din k=%0d", k), 32'(mem_in), 32'(d));
      chk($sformatf("busy k=%0d", k), 32'(busy), 32'(k < 17 * P));
      chk($sformatf("done k=%0d", k), 32'(done), 32'(k >= 17 * P + 1));
   endtask

   task automatic model(output int err, output int fail, output bit ok);
      logic [DW-1:0] d;
      err = 0;
      fail = 0;
      for (int q = 0; q < P; q++)
         foreach (addrs[j]) begin
            d = DW'(addrs[j]);
            if (q == 1) d = ~d;
            if (fault(addrs[j], d) != d) begin
               if (err == 0) fail = addrs[j];
               if (err < 255) err++;
            end
         end
      ok = err == 0;
   endtask

   task automatic run(input vec_t v);
      mode = v.mode;
      fa = v.fa;
      mask = v.mask;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k <= 17 * P + 1; k++) begin
         check_cycle(k);
         if (k == 0) begin
            chk("err_clr", 32'(err_count), 0);
            chk("fail_clr", 32'(fail_addr), 0);
            chk("pass_clr", 32'(pass), 0);
         end
         if (k < 17 * P + 1) step();
      end
      chk("err_count", 32'(err_count), 32'(v.err));
      chk("fail_addr", 32'(fail_addr), 32'(v.fail));
      chk("pass", 32'(pass), 32'(v.pass));
   endtask

   task automatic check_idle(input string name);
      chk({name, "_ctl"}, {mem_en, mem_read, mem_write, busy, done, pass, 6'd0, mem_add}, 0);
      chk({name, "_din"}, 32'(mem_in), 0);
      chk({name, "_err"}, 32'(err_count), 0);
      chk({name, "_fail"}, 32'(fail_addr), 0);
   endtask

   initial begin
      vec_t v;
      int e, f;
      bit ok;
      for (int a = SA; a <= (1 << AW) - 1; a += ST) addrs.push_back(a);
      tbl[0] = '{0, 0, 0, 0, 0, 1'b1};
      tbl[1] = '{1, 4098, 0, P, 4098, 1'b0};
      tbl[2] = '{2, 0, 0, 8 * P, 2, 1'b0};
      tbl[3] = '{0, 0, 0, 0, 0, 1'b1};
      tbl[4] = '{1, 14338, 0, P, 14338, 1'b0};

      repeat (3) step();
      check_idle("reset");
      start = 1'b1;
      step();
      check_idle("rst_over_start");
      rst = 1'b0;
      start = 1'b0;
      step();
      check_idle("idle");

      foreach (tbl[i]) run(tbl[i]);

      for (int i = 0; i < 6; i++) begin
         v.mode = (i % 2 == 0) ? 3 : 1;
         v.mask = $urandom_range(1, 255);
         v.fa = addrs[$urandom_range(0, addrs.size() - 1)];
         mode = v.mode;
         mask = v.mask;
         fa = v.fa;
         model(e, f, ok);
         v.err = e;
         v.fail = f;
         v.pass = ok;
         run(v);
      end

      mode = 0;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (10) step();
      chk("mid_rd", 32'(mem_read && !mem_write), 1);
      rst = 1'b1;
      step();
      check_idle("abort");
      rst = 1'b0;
      step();
      check_idle("abort_idle");
      run(tbl[0]);

      step();
      start = 1'b1;
      step();
      for (int k = 0; k <= 17 * P; k++) begin
         check_cycle(k);
         step();
      end
      chk("restart_wr", 32'(mem_write), 1);
      chk("restart_add", 32'(mem_add), SA);
      chk("restart_busy", 32'(busy), 1);
      chk("restart_done", 32'(done), 0);
      start = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      run(tbl[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ram_bist_ctrl.md
RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 16, RAM data width.
REQ-003 SHALL have parameter START_ADDR, default 2, first address accessed.
REQ-004 SHALL have parameter STRIDE, default 2048, address increment per access.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port start  input  1  begin test run, sampled in IDLE or DONE only.
REQ-009 SHALL have port mem_add  output  ADDR_W  RAM address.
REQ-010 SHALL have port mem_in  output  DATA_W  RAM write data.
REQ-011 SHALL have port mem_read  output  1  RAM read strobe.
REQ-012 SHALL have port mem_write  output  1  RAM write strobe.
REQ-013 SHALL have port mem_en  output  1  RAM enable.
REQ-014 SHALL have port mem_out  input  DATA_W  RAM read data, valid one cycle after a read access.
REQ-015 SHALL have ports busy (output, 1, run in progress), done (output, 1, run finished), pass (output, 1, zero mismatches).
REQ-016 SHALL have ports err_count (output, 8, mismatch count) and fail_addr (output, ADDR_W, first mismatching address).

Function
REQ-017 SHALL drive RAM accesses as: write = en,read,write all 1; read = en 1, read 1, write 0; idle = all three 0, mem_add and mem_in 0.
REQ-018 SHALL register all outputs; no combinational path from any input to any output.
REQ-019 SHALL implement FSM IDLE -> WR -> RD -> DRAIN -> DONE; DONE -> WR on start; IDLE -> WR on start.
REQ-020 SHALL in WR issue one write per cycle at addresses START_ADDR, START_ADDR+STRIDE, ..., with data = address zero-extended to DATA_W.
REQ-021 SHALL end the sequence at the last address whose value fits in ADDR_W bits, using an ADDR_W+1-bit sum; no wrap-around; defaults give 8 accesses (2 .. 14338).
REQ-022 SHALL in RD issue reads at the same address sequence, one per cycle, and compare mem_out to expected data one cycle later (pipelined); DRAIN performs the final compare only.
REQ-023 SHALL increment err_count on each mismatch, saturating at 255.
REQ-024 SHALL capture fail_addr on the first mismatch of a run only; 0 if none.
REQ-025 SHALL hold busy=1 in WR, RD, DRAIN; done=1 and pass=(err_count==0) in DONE, both held until next start or reset; pass=0 outside DONE.
REQ-026 SHALL with defaults present the first write in the cycle after the start-sampling edge and raise done 18 clocks after that edge.
REQ-027 SHALL ignore start while busy=1.
REQ-028 SHALL on start in DONE clear err_count, fail_addr, done, pass and begin WR next cycle.

Reset
REQ-029 SHALL on rst=1 at a clock edge enter IDLE and drive every output to 0 (mem strobes, mem_add, mem_in, busy, done, pass, err_count, fail_addr), including mid-run; an aborted run reports nothing.
REQ-030 SHALL give rst priority over start in the same cycle.

Configuration
REQ-031 SHALL with RAM_BIST_INV_PASS_EN defined run a second WR/RD pass after the first RD pass, data = bitwise inverse of address, errors accumulated into the same counters; done at 35 clocks for defaults.
REQ-032 SHALL without RAM_BIST_INV_PASS_EN run the single non-inverted pass only.

Structure
REQ-033 SHALL take the FSM state enum and default ADDR_W/DATA_W/START_ADDR/STRIDE constants from shared package ram_bist_pkg.
REQ-034 SHALL place address sequencing (current address, last-address flag) in sub-module ram_bist_addr_gen.

Verification
REQ-035 SHALL check: reset, start pulse, defaults, correct RAM model -> 8 writes at 2,2050,...,14338 with mem_in=address, 8 reads, done=1 at clock 18, pass=1, err_count=0.
REQ-036 SHALL check: RAM model corrupts data at address 4098 -> err_count=1, fail_addr=4098, pass=0.
REQ-037 SHALL check: RAM model outputs all-zero data always -> err_count=8, fail_addr=2.
REQ-038 SHALL check: rst asserted during RD -> all outputs 0 next cycle; start pulsed again -> clean run, pass=1.
REQ-039 SHALL check: start held high through a whole run -> start ignored while busy; run restarts immediately after DONE is entered.
REQ-040 SHALL check: RAM_BIST_INV_PASS_EN defined -> second pass writes ~address (e.g. 0xFFFD at address 2), done at clock 35, pass=1.
